uart_duty_rx: RTL
=================

# uart_duty_rx

Serial receiver that sets the PWM duty value from a UART link. It decodes 8N1 frames from the serial input pin and holds the last good byte in an 8-bit duty register. The register drives the compare input of the downstream PWM generator. It reports each update with a one-cycle strobe and flags malformed frames.

## Interface
Parameters:
- TICK_DIV, 65, clk cycles per oversample tick. 10 MHz / (9600 baud × 16) = 65.1, truncated to 65. Legal range 2..65535.
- DUTY_RST, 8'h00, reset value of duty_o.

Ports:
- clk  input  1  system clock (10 MHz nominal).
- rst_i  input  1  reset. One clock; reset is asynchronous and active-high.
- rx_i  input  1  asynchronous serial line; idles high.
- duty_o  output  8  last correctly framed byte; feeds the PWM compare input.
- duty_valid_o  output  1  one-cycle pulse when duty_o is updated.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1. All decisions below use the synchronized value (rxs).
- Tick counter:
  - 16-bit, counts 0..TICK_DIV-1.
  - The tick pulse fires in the cycle when count == TICK_DIV-1; the count then wraps to 0.
  - The counter is held at 0 in IDLE and WAIT_HIGH.
- Tick count within a bit: 4-bit, cleared on every state entry.
- Bit index: 3-bit.
- Shift register: 8-bit. Bits are shifted in LSB first (shift right, new bit into bit 7).
- States:
  - IDLE: rxs == 0 → START.
  - START: on the 8th tick (mid start bit), sample rxs. If 0 → DATA with bit index 0. If 1 → IDLE; this is glitch rejection and produces no output.
  - DATA: on every 16th tick, sample rxs into the shift register. After bit index 7 is sampled → STOP; otherwise increment the bit index.
  - STOP: on the 16th tick, sample rxs.
    - If 1: load duty_o ← shift register, pulse duty_valid_o, go to IDLE.
    - If 0: pulse frame_err_o, leave duty_o unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: rxs == 1 → IDLE. A held-low (break) line therefore yields only one error pulse.
- duty_valid_o and frame_err_o are registered. They are never high in the same cycle.
- There is no parity and no flow control. Bytes arriving back-to-back with a single stop bit must all be received.

## Timing
- Reset values:
  - duty_o = DUTY_RST.
  - duty_valid_o = 0, frame_err_o = 0, busy_o = 0.
  - State = IDLE; all counters and the shift register = 0.
- Reset mid-frame discards the partial byte. After release the block waits in IDLE for a new falling edge. A line already low at release is treated as a start bit.
- Start detection: rx_i falling at edge n gives rxs == 0 at edge n+2. The state becomes START at edge n+3, and busy_o rises the same cycle.
- Frame latency: the start sample occurs 8·TICK_DIV cycles after START entry. Each data sample and the stop sample occur 16·TICK_DIV after the previous one. duty_valid_o rises 152·TICK_DIV + 3 cycles after the falling edge of rx_i, ±1 cycle. This is 9883 cycles at the default.
- duty_o changes in the same cycle duty_valid_o is high and is stable otherwise.
- Re-arm: after STOP returns to IDLE, a start bit beginning immediately is accepted. With the sampling point at 16 ticks, at least 8 ticks of margin remain before the next mid-start sample.
- Sampling-point error at the default divisor is 0.16 % per bit (65 vs 65.1 cycles/tick). This is within the tolerance of an 8N1 frame.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle → all outputs go to reset values immediately. After release, rx_i idle high for 2000 cycles → no pulses, busy_o = 0.
- Single byte: send 0x80 at 104 170 ns/bit (9600 baud) → duty_o = 0x80 with one duty_valid_o pulse at 9883 ±1 cycles after the start edge. frame_err_o stays 0.
- Back-to-back: send 0x00, 0xFF, 0x5A with no idle gap → three valid pulses; duty_o shows 0x00, 0xFF, 0x5A in order.
- Glitch: drive rx_i low for 300 cycles (< 8 ticks) then high → busy_o returns to 0 within 8·TICK_DIV + 3 cycles. No pulses; duty_o unchanged.
- Framing error: send 0x33 with stop bit 0, then hold rx_i low 5000 cycles, then high and send 0x44 → one frame_err_o pulse and duty_o keeps its prior value. Then one valid pulse with duty_o = 0x44.
- Reset mid-frame: assert rst_i during bit 4 of 0xC3 → duty_o = DUTY_RST and no valid pulse. The next full frame, 0x12, is received correctly.

Source files
------------

// File: rtl/uart_duty_rx.sv
`timescale 1ns/1ps
// uart_duty_rx: 8N1 UART receiver that loads the PWM duty register.
// Ports:
//   clk           system clock
//   rst_i         async active-high reset
//   rx_i          serial line, idles high
//   duty_o        last good byte
//   duty_valid_o  1-cycle pulse on duty_o update
//   frame_err_o   1-cycle pulse on low stop bit
//   busy_o        high while not IDLE
module uart_duty_rx #(
  parameter int unsigned TICK_DIV = 65,
  parameter logic [7:0]  DUTY_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] duty_o,
  output logic       duty_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [15:0] div_q;
  logic [3:0]  tcnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        counting;
  logic        tick;
  logic        rxs;

  assign rxs      = rx_sync_q;
  // Tick divider only runs while a frame is being timed.
  assign counting = (state_q == START) || (state_q == DATA) ||
                    (state_q == STOP);
  assign tick     = counting && (div_q == DIV_LAST);
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      div_q        <= '0;
      tcnt_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      duty_o       <= DUTY_RST;
      duty_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      duty_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;

      if (!counting || tick) div_q <= '0;
      else                   div_q <= div_q + 16'd1;

      if (tick) tcnt_q <= tcnt_q + 4'd1;

      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            tcnt_q  <= '0;
          end
        end
        START: begin
          // Mid start bit: a high line here was only a glitch.
          if (tick && tcnt_q == 4'd7) begin
            tcnt_q <= '0;
            if (!rxs) begin
              state_q <= DATA;
              bit_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && tcnt_q == 4'd15) begin
            tcnt_q  <= '0;
            shift_q <= {rxs, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        STOP: begin
          if (tick && tcnt_q == 4'd15) begin
            tcnt_q <= '0;
            if (rxs) begin
              duty_o       <= shift_q;
              duty_valid_o <= 1'b1;
              state_q      <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // Break condition: stay here until the line returns high.
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
